// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - opcodes, FSM states and decode helpers for the multi-cycle MIPS core
package mips_mc_pkg;

  localparam int INSTR_W  = 16;
  localparam int OP_W     = 4;
  localparam int REG_AW   = 4;
  localparam int NUM_REGS = 16;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OP_W-1:0] OP_LW   = 4'h3;
  localparam logic [OP_W-1:0] OP_SW   = 4'h4;
  localparam logic [OP_W-1:0] OP_J    = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
  localparam logic [OP_W-1:0] OP_OR   = 4'h7;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h8;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR
  } alu_op_e;

  // Everything that is not SUB/XOR/OR adds (ADDI/LW/SW address, J/BEQ/NOP/HALT a+b).
  function automatic alu_op_e alu_op_of(input logic [OP_W-1:0] op);
    alu_op_e r;
    case (op)
      OP_SUB:  r = ALU_SUB;
      OP_XOR:  r = ALU_XOR;
      OP_OR:   r = ALU_OR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Ops whose second ALU operand is the sign-extended C field.
  function automatic logic uses_imm(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_multi_cycle_core_if.sv
// rtl/mips_multi_cycle_core_if.sv - host control / program-load / status bundle of the core
interface mips_multi_cycle_core_if
  import mips_mc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMEM_DEPTH = 16
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);

  logic               run;
  logic               load_we;
  logic [IMEM_AW-1:0] load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               busy;
  logic               halted;
  logic               retire;
  logic [IMEM_AW-1:0] pc_q;
  logic [DATA_W-1:0]  alu_q;

  modport master (
    output run, load_we, load_addr, load_data,
    input  busy, halted, retire, pc_q, alu_q
  );

  modport slave (
    input  run, load_we, load_addr, load_data,
    output busy, halted, retire, pc_q, alu_q
  );
endinterface

// File: rtl/mips_mc_alu.sv
// rtl/mips_mc_alu.sv - combinational ALU (add/sub/xor/or, modulo 2^DATA_W, no flags)
module mips_mc_alu
  import mips_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  // Single shared function unit; result wraps naturally at DATA_W bits.
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      ALU_OR:  o_y = i_a | i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/mips_multi_cycle_core.sv
// rtl/mips_multi_cycle_core.sv - multi-cycle 16-bit MIPS-like core with loadable program RAM
module mips_multi_cycle_core
  import mips_mc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multi_cycle_core_if.slave bus
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  state_e             r_state;
  state_e             w_next;
  logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  r_regs [NUM_REGS];
  logic [DATA_W-1:0]  r_dmem [DMEM_DEPTH];
  logic [INSTR_W-1:0] r_ir;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_imm;
  logic [DATA_W-1:0]  r_alu;
  logic [DATA_W-1:0]  r_mdr;
  logic [IMEM_AW-1:0] r_pc;

  logic [OP_W-1:0]    w_op;
  logic [REG_AW-1:0]  w_fa;
  logic [REG_AW-1:0]  w_fb;
  logic [REG_AW-1:0]  w_fc;
  logic [DATA_W-1:0]  w_rd_a;
  logic [DATA_W-1:0]  w_rd_b;
  logic [DATA_W-1:0]  w_rd_c;
  logic [DATA_W-1:0]  w_alu_b;
  logic [DATA_W-1:0]  w_alu_y;
  logic [IMEM_AW-1:0] w_pc_inc;
  logic [IMEM_AW-1:0] w_pc_next;
  logic               w_ctrl_idle;
  logic               w_load;
  logic               w_busy;
  logic               w_halted;
  logic               w_retire;

  assign w_op = r_ir[15:12];
  assign w_fa = r_ir[11:8];
  assign w_fb = r_ir[7:4];
  assign w_fc = r_ir[3:0];

  // r0 reads as zero no matter what the array holds.
  assign w_rd_a = (w_fa == '0) ? '0 : r_regs[w_fa];
  assign w_rd_b = (w_fb == '0) ? '0 : r_regs[w_fb];
  assign w_rd_c = (w_fc == '0) ? '0 : r_regs[w_fc];

  assign w_alu_b = uses_imm(w_op) ? r_imm : r_b;

  mips_mc_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op (alu_op_of(w_op)),
    .i_a  (r_a),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y)
  );

  // For BEQ r_a holds R[B] and r_b holds R[A]; r_imm is already sign-extended, so its low bits wrap the pc.
  assign w_pc_inc = r_pc + IMEM_AW'(1);
  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_op)
      OP_J:    w_pc_next = r_ir[IMEM_AW-1:0];
      OP_HALT: w_pc_next = r_pc;
      OP_BEQ:  if (r_a == r_b) w_pc_next = w_pc_inc + r_imm[IMEM_AW-1:0];
      default: w_pc_next = w_pc_inc;
    endcase
  end

  // The host may only touch the program or restart while the core is parked.
  assign w_ctrl_idle = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_load      = bus.load_we && w_ctrl_idle;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state plus status outputs; retire marks the last cycle of every instruction.
  always_comb begin
    w_next   = r_state;
    w_busy   = 1'b0;
    w_halted = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run) w_next = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (bus.run) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_busy = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_busy = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        w_busy = 1'b1;
        case (w_op)
          OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_ADDI: w_next = S_WB;
          OP_LW, OP_SW: w_next = S_MEM;
          OP_HALT: begin
            w_next   = S_HALT;
            w_retire = 1'b1;
          end
          default: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        w_busy = 1'b1;
        if (w_op == OP_LW) begin
          w_next = S_WB;
        end else begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_WB: begin
        w_busy   = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Program RAM: written only by the host, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_load) r_imem[bus.load_addr] <= bus.load_data;
  end

  // Datapath registers, register file and data memory, advanced one FSM step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_imm <= '0;
      r_alu <= '0;
      r_mdr <= '0;
      r_pc  <= '0;
      for (int i = 0; i < NUM_REGS; i++)   r_regs[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.run) r_pc <= '0;
        end
        S_FETCH: r_ir <= r_imem[r_pc];
        S_DECODE: begin
          r_a   <= w_rd_b;
          r_b   <= ((w_op == OP_SW) || (w_op == OP_BEQ)) ? w_rd_a : w_rd_c;
          r_imm <= {{(DATA_W-4){w_fc[3]}}, w_fc};
        end
        S_EXEC: begin
          r_alu <= w_alu_y;
          r_pc  <= w_pc_next;
        end
        S_MEM: begin
          if (w_op == OP_LW) r_mdr <= r_dmem[r_alu[DMEM_AW-1:0]];
          else               r_dmem[r_alu[DMEM_AW-1:0]] <= r_b;
        end
        S_WB: begin
          if (w_fa != '0) r_regs[w_fa] <= (w_op == OP_LW) ? r_mdr : r_alu;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.halted = w_halted;
  assign bus.retire = w_retire;
  assign bus.pc_q   = r_pc;
  assign bus.alu_q  = r_alu;

endmodule

// File: tb/tb_mips_multi_cycle_core.sv
// tb/tb_mips_multi_cycle_core.sv - directed self-checking bench for mips_multi_cycle_core
module tb_mips_multi_cycle_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc;
  int   rets;
  int   ret_at [16];
  int   cnt;
  int   n;
  bit   bad;

  always #5 clk = ~clk;

  mips_multi_cycle_core_if #(.DATA_W(16), .IMEM_DEPTH(16)) bus ();

  mips_multi_cycle_core #(
    .DATA_W     (16),
    .IMEM_DEPTH (16),
    .DMEM_DEPTH (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [15:0] data);
    @(negedge clk);
    bus.load_we   = 1'b1;
    bus.load_addr = addr[3:0];
    bus.load_data = data;
    @(negedge clk);
    bus.load_we   = 1'b0;
  endtask

  task automatic run_prog(input bit with_load, input int la, input logic [15:0] ld);
    @(negedge clk);
    bus.run = 1'b1;
    if (with_load) begin
      bus.load_we   = 1'b1;
      bus.load_addr = la[3:0];
      bus.load_data = ld;
    end
    @(negedge clk);
    bus.run     = 1'b0;
    bus.load_we = 1'b0;
    cyc  = 0;
    rets = 0;
    n    = 0;
    while (!bus.halted && n < 400) begin
      if (bus.busy) cyc++;
      if (bus.retire) begin
        if (rets < 16) ret_at[rets] = cyc;
        rets++;
      end
      n++;
      @(negedge clk);
    end
    chk("halt_reached", bus.halted, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},   bus.busy,   0);
    chk({tag, "_halted"}, bus.halted, 0);
    chk({tag, "_retire"}, bus.retire, 0);
    chk({tag, "_pc"},     bus.pc_q,   0);
    chk({tag, "_alu"},    bus.alu_q,  0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.run       = 1'b0;
    bus.load_we   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI r1=5; ADDI r2=-3; ADD r3=r1+r2; HALT reading r3
    load(0, 16'h2105);
    load(1, 16'h220D);
    load(2, 16'h0312);
    load(3, 16'hF030);
    run_prog(1'b0, 0, 16'h0);
    chk("p1_cycles",  cyc, 15);
    chk("p1_retires", rets, 4);
    chk("p1_alu_r3",  bus.alu_q, 16'h0002);
    chk("p1_pc",      bus.pc_q, 3);
    chk("p1_busy",    bus.busy, 0);

    // ADDI r1=7; SW r1->dmem[9]; LW r4<-dmem[9]; HALT reading r4
    load(0, 16'h2107);
    load(1, 16'h4109);
    load(2, 16'h3409);
    load(3, 16'hF040);
    run_prog(1'b0, 0, 16'h0);
    chk("p2_cycles",   cyc, 16);
    chk("p2_addi_len", ret_at[0], 4);
    chk("p2_sw_len",   ret_at[1] - ret_at[0], 4);
    chk("p2_lw_len",   ret_at[2] - ret_at[1], 5);
    chk("p2_halt_len", ret_at[3] - ret_at[2], 3);
    chk("p2_alu_r4",   bus.alu_q, 16'h0007);

    // XOR / OR: 6^3=5, 6|3=7, 5+7=12
    load(0, 16'h2106);
    load(1, 16'h2203);
    load(2, 16'h6312);
    load(3, 16'h7412);
    load(4, 16'h0534);
    load(5, 16'hF050);
    run_prog(1'b0, 0, 16'h0);
    chk("p3_cycles", cyc, 23);
    chk("p3_alu",    bus.alu_q, 16'h000C);
    chk("p3_pc",     bus.pc_q, 5);

    // BEQ taken at pc 3 with C=2 lands on pc 6
    load(0, 16'h2101);
    load(1, 16'h2202);
    load(2, 16'h9000);
    load(3, 16'h8112);
    load(4, 16'hF000);
    load(5, 16'hF000);
    load(6, 16'hF000);
    run_prog(1'b0, 0, 16'h0);
    chk("beq_taken_pc",     bus.pc_q, 6);
    chk("beq_taken_cycles", cyc, 17);

    // BEQ not taken (r1=1, r2=2) falls through to pc 4
    load(3, 16'h8122);
    run_prog(1'b0, 0, 16'h0);
    chk("beq_nt_pc", bus.pc_q, 4);

    // BEQ r0,r0,-1 at pc 5 spins on pc 5
    load(4, 16'h9000);
    load(5, 16'h800F);
    @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    repeat (30) @(negedge clk);
    chk("beq_neg_pc",     bus.pc_q, 5);
    chk("beq_neg_busy",   bus.busy, 1);
    chk("beq_neg_halted", bus.halted, 0);

    // load_we / run while busy must be ignored
    bus.load_we   = 1'b1;
    bus.load_addr = 4'd5;
    bus.load_data = 16'hF000;
    bus.run       = 1'b1;
    @(negedge clk);
    bus.load_we = 1'b0;
    bus.run     = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.pc_q != 4'd5) bad = 1'b1;
    end
    chk("busy_ignore_pc",     bad, 0);
    chk("busy_ignore_halted", bus.halted, 0);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("loop_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ r6==r0 skips HALT, SUB 0-1, J 15, NOP wraps to 0, BEQ falls through to HALT
    load(0, 16'h8601);
    load(1, 16'hF070);
    load(2, 16'h2601);
    load(3, 16'h1706);
    load(4, 16'h500F);
    load(15, 16'h9000);
    run_prog(1'b0, 0, 16'h0);
    chk("wrap_pc",      bus.pc_q, 1);
    chk("wrap_sub_alu", bus.alu_q, 16'hFFFF);
    chk("wrap_retires", rets, 7);
    chk("wrap_cycles",  cyc, 23);

    // write to r0 is dropped; ADD r5,r0,r0 gives 0
    load(0, 16'h2005);
    load(1, 16'h0500);
    load(2, 16'hF050);
    run_prog(1'b0, 0, 16'h0);
    chk("r0_alu",     bus.alu_q, 16'h0000);
    chk("r0_retires", rets, 3);

    // reset asserted in the MEM cycle of SW
    load(0, 16'h2107);
    load(1, 16'h4109);
    load(2, 16'h3409);
    load(3, 16'hF040);
    @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    cnt = 0;
    n   = 0;
    while (n < 50) begin
      if (bus.busy) cnt++;
      if (cnt == 8) break;
      n++;
      @(negedge clk);
    end
    chk("sw_mem_reached", cnt, 8);
    chk("sw_mem_retire",  bus.retire, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_sw_reset");
    @(negedge clk);
    chk_reset_outputs("mid_sw_reset_held");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy",   bus.busy, 0);
    chk("post_reset_halted", bus.halted, 0);

    // load word 0 in the same cycle as run; the first fetch must see the new word
    load(1, 16'hF041);
    run_prog(1'b1, 0, 16'h3409);
    chk("ldrun_cycles", cyc, 8);
    chk("ldrun_alu",    bus.alu_q, 16'h0000);
    chk("ldrun_pc",     bus.pc_q, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
